// File: rtl/gobang_pkg.sv
// Shared Gobang types and constants: board layout, cell encoding, watchdog limit
// and the move-search FSM state type.
package gobang_pkg;

    localparam int unsigned BOARD_CELLS = 225;
    localparam logic [7:0]  LAST_CELL   = 8'd224;

    localparam logic [1:0] CELL_EMPTY = 2'd0;
    localparam logic [1:0] CELL_BLACK = 2'd1;
    localparam logic [1:0] CELL_WHITE = 2'd2;

    localparam logic [7:0] WD_LIMIT = 8'd255;

    // Row-major board, cell index = row*15+col.
    typedef logic [BOARD_CELLS-1:0][1:0] board_t;

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StLaunch,
        StWait,
        StUpdate,
        StDone
    } search_state_e;

    function automatic logic [1:0] mover_stone(input logic turn);
        return turn ? CELL_WHITE : CELL_BLACK;
    endfunction

endpackage

// File: rtl/move_search_ctrl.sv
// Exhaustive one-ply move search: tries every empty cell through an external
// point generator and keeps the highest-scoring cell (lowest index on ties).
module move_search_ctrl
    import gobang_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  board_t      i_board,
    input  logic        i_turn,
    output logic        o_pg_start,
    output board_t      o_pg_board,
    output logic        o_pg_turn,
    input  logic [31:0] i_pg_score,
    input  logic        i_pg_finish,
    output logic [7:0]  o_best_pos,
    output logic [31:0] o_best_score,
    output logic        o_valid,
    output logic        o_timeout,
    output logic        o_busy,
    output logic        o_finish
);

    search_state_e state_q, state_d;
    board_t        board_q, board_d;
    logic          turn_q, turn_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    wd_q, wd_d;
    logic [31:0]   score_q, score_d;
    logic [7:0]    best_pos_q, best_pos_d;
    logic [31:0]   best_score_q, best_score_d;
    logic          valid_q, valid_d;
    logic          timeout_q, timeout_d;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= StIdle;
            board_q      <= '0;
            turn_q       <= 1'b0;
            idx_q        <= '0;
            wd_q         <= '0;
            score_q      <= '0;
            best_pos_q   <= '0;
            best_score_q <= '0;
            valid_q      <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            turn_q       <= turn_d;
            idx_q        <= idx_d;
            wd_q         <= wd_d;
            score_q      <= score_d;
            best_pos_q   <= best_pos_d;
            best_score_q <= best_score_d;
            valid_q      <= valid_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        board_d      = board_q;
        turn_d       = turn_q;
        idx_d        = idx_q;
        wd_d         = wd_q;
        score_d      = score_q;
        best_pos_d   = best_pos_q;
        best_score_d = best_score_q;
        valid_d      = valid_q;
        timeout_d    = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    board_d      = i_board;
                    turn_d       = i_turn;
                    idx_d        = '0;
                    best_pos_d   = '0;
                    best_score_d = '0;
                    valid_d      = 1'b0;
                    timeout_d    = 1'b0;
                    state_d      = StScan;
                end
            end
            StScan: begin
                if (board_q[idx_q] == CELL_EMPTY) begin
                    state_d = StLaunch;
                end else if (idx_q == LAST_CELL) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            StLaunch: begin
                wd_d    = '0;
                state_d = StWait;
            end
            StWait: begin
                if (i_pg_finish) begin
                    score_d = i_pg_score;
                    state_d = StUpdate;
                end else if (wd_q == WD_LIMIT - 8'd1) begin
                    // Stalled generator: score the cell as 0 and move on.
                    score_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = StUpdate;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            StUpdate: begin
                if (!valid_q || (score_q > best_score_q)) begin
                    best_pos_d   = idx_q;
                    best_score_d = score_q;
                end
                valid_d = 1'b1;
                if (idx_q == LAST_CELL) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = StScan;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Candidate stone is only overlaid while an evaluation is in flight.
    always_comb begin
        o_pg_board = board_q;
        if (state_q == StLaunch || state_q == StWait || state_q == StUpdate) begin
            o_pg_board[idx_q] = mover_stone(turn_q);
        end
    end

    assign o_pg_start   = (state_q == StLaunch) && i_rst_n;
    assign o_pg_turn    = turn_q;
    assign o_best_pos   = best_pos_q;
    assign o_best_score = best_score_q;
    assign o_valid      = valid_q;
    assign o_timeout    = timeout_q;
    assign o_busy       = (state_q != StIdle);
    assign o_finish     = (state_q == StDone);

endmodule

// File: tb/tb_move_search_ctrl.sv
// Self-checking bench for move_search_ctrl with a stub point generator and a
// reference model computing the best empty cell from a score table.
module tb_move_search_ctrl;
    import gobang_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    board_t      i_board;
    logic        i_turn;
    logic        o_pg_start;
    board_t      o_pg_board;
    logic        o_pg_turn;
    logic [31:0] i_pg_score;
    logic        i_pg_finish;
    logic [7:0]  o_best_pos;
    logic [31:0] o_best_score;
    logic        o_valid;
    logic        o_timeout;
    logic        o_busy;
    logic        o_finish;

    int n_checks = 0;
    int n_pass   = 0;

    board_t      cur_board;
    logic        cur_turn;
    int unsigned score_tab [BOARD_CELLS];
    int          lat      = 4;
    int          hang_idx = -1;
    int          launch_cnt = 0;

    int          stub_diff;
    int          stub_cell;
    logic [1:0]  stub_stone;

    always #5 clk = ~clk;

    move_search_ctrl dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (i_start),
        .i_board      (i_board),
        .i_turn       (i_turn),
        .o_pg_start   (o_pg_start),
        .o_pg_board   (o_pg_board),
        .o_pg_turn    (o_pg_turn),
        .i_pg_score   (i_pg_score),
        .i_pg_finish  (i_pg_finish),
        .o_best_pos   (o_best_pos),
        .o_best_score (o_best_score),
        .o_valid      (o_valid),
        .o_timeout    (o_timeout),
        .o_busy       (o_busy),
        .o_finish     (o_finish)
    );

    // Stub point generator: answers score_tab[cell] after lat cycles, never for hang_idx.
    initial begin
        i_pg_finish = 1'b0;
        i_pg_score  = '0;
        forever begin
            @(posedge clk); #1;
            if (o_pg_start === 1'b1) begin
                stub_diff  = 0;
                stub_cell  = 0;
                stub_stone = cur_turn ? 2'd2 : 2'd1;
                for (int i = 0; i < BOARD_CELLS; i++) begin
                    if (o_pg_board[i] !== cur_board[i]) begin
                        stub_diff++;
                        stub_cell = i;
                    end
                end
                launch_cnt++;
                n_checks++;
                if (stub_diff != 1 || o_pg_board[stub_cell] !== stub_stone ||
                    o_pg_turn !== cur_turn) begin
                    $display("FAIL pg_board: %0d changed cells, cell %0d=%0d turn %0b; need 1 cell = %0d turn %0b",
                             stub_diff, stub_cell, o_pg_board[stub_cell], o_pg_turn,
                             stub_stone, cur_turn);
                end else begin
                    n_pass++;
                end
                if (stub_cell != hang_idx) begin
                    repeat (lat) @(posedge clk);
                    #1;
                    i_pg_finish = 1'b1;
                    i_pg_score  = score_tab[stub_cell];
                    @(posedge clk); #1;
                    i_pg_finish = 1'b0;
                    i_pg_score  = $urandom;
                end
            end
        end
    end

    // Best = maximum score over empty cells, earliest cell among equals.
    function automatic void ref_model(input board_t b, input int hang, output int pos,
                                      output int unsigned sc, output bit v, output bit to);
        int unsigned mx;
        int unsigned s;
        mx  = 0;
        v   = 1'b0;
        to  = 1'b0;
        pos = 0;
        sc  = 0;
        for (int i = 0; i < BOARD_CELLS; i++) begin
            if (b[i] == 2'd0) begin
                s = (i == hang) ? 0 : score_tab[i];
                if (i == hang) to = 1'b1;
                if (s > mx) mx = s;
                v = 1'b1;
            end
        end
        if (v) begin
            sc = mx;
            for (int i = BOARD_CELLS - 1; i >= 0; i--) begin
                if (b[i] == 2'd0 && ((i == hang) ? 0 : score_tab[i]) == mx) pos = i;
            end
        end
    endfunction

    task automatic run_search(input board_t b, input logic t, output int ncyc,
                              output int nfin, output bit done);
        cur_board = b;
        cur_turn  = t;
        @(posedge clk); #1;
        i_board = b;
        i_turn  = t;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_board = '0;
        ncyc = 1;
        nfin = 0;
        done = 1'b0;
        while (!done && ncyc < 20000) begin
            if (o_finish === 1'b1) done = 1'b1;
            else begin
                @(posedge clk); #1;
                ncyc++;
            end
        end
        if (done) begin
            nfin = 1;
            repeat (3) begin
                @(posedge clk); #1;
                if (o_finish === 1'b1) nfin++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        i_start = 1'b0;
        i_board = '0;
        i_turn  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (o_busy !== 1'b0 || o_finish !== 1'b0 || o_pg_start !== 1'b0) begin
            $display("FAIL reset_ctrl: busy %b finish %b pg_start %b, need 0 0 0",
                     o_busy, o_finish, o_pg_start);
        end else n_pass++;
        n_checks++;
        if (o_best_pos !== 8'd0 || o_best_score !== 32'd0 || o_valid !== 1'b0 ||
            o_timeout !== 1'b0) begin
            $display("FAIL reset_results: pos %0d score %0d valid %b timeout %b, need all 0",
                     o_best_pos, o_best_score, o_valid, o_timeout);
        end else n_pass++;
        n_checks++;
        if (o_pg_board !== '0 || o_pg_turn !== 1'b0) begin
            $display("FAIL reset_pg: pg_board nonzero %b turn %b, need 0", o_pg_board != '0,
                     o_pg_turn);
        end else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_empty_board();
        int ncyc, nfin, base;
        bit done;
        for (int i = 0; i < BOARD_CELLS; i++) score_tab[i] = i * 3;
        lat      = 4;
        hang_idx = -1;
        base     = launch_cnt;
        run_search('0, 1'b0, ncyc, nfin, done);
        n_checks++;
        if (!done || nfin != 1) begin
            $display("FAIL empty_finish: done %b pulses %0d, need done 1 pulses 1", done, nfin);
        end else n_pass++;
        n_checks++;
        if (o_best_pos !== 8'd224 || o_best_score !== 32'd672 || o_valid !== 1'b1 ||
            o_timeout !== 1'b0) begin
            $display("FAIL empty_result: pos %0d score %0d valid %b to %b, need 224 672 1 0",
                     o_best_pos, o_best_score, o_valid, o_timeout);
        end else n_pass++;
        n_checks++;
        if (launch_cnt - base != 225) begin
            $display("FAIL empty_launches: got %0d, need 225", launch_cnt - base);
        end else n_pass++;
    endtask

    task automatic test_full_board();
        board_t b;
        int ncyc, nfin, base;
        bit done;
        for (int i = 0; i < BOARD_CELLS; i++) b[i] = 2'($urandom_range(1, 3));
        base = launch_cnt;
        run_search(b, 1'($urandom_range(0, 1)), ncyc, nfin, done);
        n_checks++;
        if (!done || ncyc != 226 || nfin != 1) begin
            $display("FAIL full_timing: finish after %0d cycles pulses %0d, need 226 and 1",
                     ncyc, nfin);
        end else n_pass++;
        n_checks++;
        if (o_valid !== 1'b0 || o_best_pos !== 8'd0 || o_best_score !== 32'd0 ||
            launch_cnt != base) begin
            $display("FAIL full_result: valid %b pos %0d score %0d launches %0d, need 0 0 0 0",
                     o_valid, o_best_pos, o_best_score, launch_cnt - base);
        end else n_pass++;
    endtask

    task automatic test_tie();
        board_t b;
        int ncyc, nfin;
        bit done;
        for (int i = 0; i < BOARD_CELLS; i++) begin
            b[i]         = 2'd1;
            score_tab[i] = 500;
        end
        b[10] = 2'd0;
        b[20] = 2'd0;
        run_search(b, 1'b0, ncyc, nfin, done);
        n_checks++;
        if (!done || o_best_pos !== 8'd10 || o_best_score !== 32'd500 || o_valid !== 1'b1) begin
            $display("FAIL tie: pos %0d score %0d valid %b, need 10 500 1",
                     o_best_pos, o_best_score, o_valid);
        end else n_pass++;
    endtask

    task automatic test_timeout();
        board_t b;
        int ncyc, nfin;
        bit done;
        for (int i = 0; i < BOARD_CELLS; i++) b[i] = 2'd2;
        b[5]         = 2'd0;
        score_tab[5] = 777;
        hang_idx     = 5;
        run_search(b, 1'b1, ncyc, nfin, done);
        hang_idx = -1;
        n_checks++;
        if (!done || o_timeout !== 1'b1 || o_best_pos !== 8'd5 || o_best_score !== 32'd0 ||
            o_valid !== 1'b1) begin
            $display("FAIL timeout: done %b to %b pos %0d score %0d valid %b, need 1 1 5 0 1",
                     done, o_timeout, o_best_pos, o_best_score, o_valid);
        end else n_pass++;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (o_busy !== 1'b0 || o_best_pos !== 8'd5 || o_timeout !== 1'b1) begin
            $display("FAIL hold: busy %b pos %0d to %b, need 0 5 1", o_busy, o_best_pos,
                     o_timeout);
        end else n_pass++;
    endtask

    task automatic test_second_start();
        board_t b;
        int ncyc, base;
        bit done;
        for (int i = 0; i < BOARD_CELLS; i++) b[i] = 2'd3;
        b[10]         = 2'd0;
        b[20]         = 2'd0;
        score_tab[10] = 100;
        score_tab[20] = 300;
        cur_board     = b;
        cur_turn      = 1'b0;
        base          = launch_cnt;
        @(posedge clk); #1;
        i_board = b;
        i_turn  = 1'b0;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        i_board = '0;
        i_turn  = 1'b1;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        ncyc = 0;
        done = 1'b0;
        while (!done && ncyc < 5000) begin
            if (o_finish === 1'b1) done = 1'b1;
            else begin
                @(posedge clk); #1;
                ncyc++;
            end
        end
        n_checks++;
        if (!done || o_best_pos !== 8'd20 || o_best_score !== 32'd300 ||
            launch_cnt - base != 2) begin
            $display("FAIL second_start: done %b pos %0d score %0d launches %0d, need 1 20 300 2",
                     done, o_best_pos, o_best_score, launch_cnt - base);
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        board_t b;
        int base, ncyc;
        for (int i = 0; i < BOARD_CELLS; i++) b[i] = 2'd1;
        b[3]         = 2'd0;
        b[200]       = 2'd0;
        score_tab[3] = 42;
        hang_idx     = 200;
        cur_board    = b;
        cur_turn     = 1'b1;
        base         = launch_cnt;
        @(posedge clk); #1;
        i_board = b;
        i_turn  = 1'b1;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        ncyc = 0;
        while (launch_cnt - base < 2 && ncyc < 2000) begin
            @(posedge clk); #1;
            ncyc++;
        end
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (launch_cnt - base != 2 || o_busy !== 1'b1 || o_valid !== 1'b1 ||
            o_best_pos !== 8'd3) begin
            $display("FAIL mid_state: launches %0d busy %b valid %b pos %0d, need 2 1 1 3",
                     launch_cnt - base, o_busy, o_valid, o_best_pos);
        end else n_pass++;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_best_pos !== 8'd0 ||
            o_best_score !== 32'd0 || o_timeout !== 1'b0 || o_pg_start !== 1'b0 ||
            o_finish !== 1'b0 || o_pg_board !== '0 || o_pg_turn !== 1'b0) begin
            $display("FAIL mid_reset: busy %b valid %b pos %0d score %0d to %b pgs %b fin %b",
                     o_busy, o_valid, o_best_pos, o_best_score, o_timeout, o_pg_start, o_finish);
        end else n_pass++;
        rst_n    = 1'b1;
        hang_idx = -1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        board_t b;
        int ncyc, nfin, base, hang, nempty, exp_pos;
        int unsigned exp_sc, r;
        bit done, exp_v, exp_to;
        for (int it = 0; it < 6; it++) begin
            nempty = 0;
            for (int i = 0; i < BOARD_CELLS; i++) begin
                r = $urandom_range(0, 9);
                b[i] = (r < 3) ? 2'd0 : 2'(r % 3 + 1);
                if (b[i] == 2'd0) nempty++;
                score_tab[i] = $urandom_range(0, 63);
            end
            hang = -1;
            if (it % 2 == 1 && nempty > 0) begin
                for (int i = 0; i < BOARD_CELLS; i++) if (b[i] == 2'd0 && hang < 0 &&
                    $urandom_range(0, 3) == 0) hang = i;
            end
            hang_idx = hang;
            lat      = $urandom_range(1, 6);
            ref_model(b, hang, exp_pos, exp_sc, exp_v, exp_to);
            base = launch_cnt;
            run_search(b, 1'($urandom_range(0, 1)), ncyc, nfin, done);
            n_checks++;
            if (!done || o_best_pos !== 8'(exp_pos) || o_best_score !== exp_sc ||
                o_valid !== exp_v || o_timeout !== exp_to || launch_cnt - base != nempty) begin
                $display("FAIL random_%0d: pos %0d score %0d valid %b to %b launches %0d, need %0d %0d %b %b %0d",
                         it, o_best_pos, o_best_score, o_valid, o_timeout, launch_cnt - base,
                         exp_pos, exp_sc, exp_v, exp_to, nempty);
            end else n_pass++;
        end
        hang_idx = -1;
        lat      = 4;
    endtask

    initial begin
        test_reset();
        test_empty_board();
        test_full_board();
        test_tie();
        test_timeout();
        test_second_start();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
